// File: rtl/wb_pkg.sv
// Shared writeback types and constants.
//   wb_req_t  : one register-file write (destination + data)
//   REG_X0    : hard-wired zero register, never written
//   WB_ADDR_W : register address width
//   WB_DATA_W : register data width
package wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  localparam logic [WB_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the completion sources / register file and the
// writeback arbiter.
//   i_alu_*  : ALU completion (valid, rd, data), no back-pressure
//   i_lsu_*  : LSU completion (valid, rd, data), with o_lsu_ready
//   o_rd_*   : register file write port
//   o_alu_stall, o_pending, o_err : hazard / status outputs
// master = sources + register file side, slave = the arbiter.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                 i_alu_valid;
  logic [WB_ADDR_W-1:0] i_alu_rd;
  logic [WB_DATA_W-1:0] i_alu_data;
  logic                 i_lsu_valid;
  logic                 o_lsu_ready;
  logic [WB_ADDR_W-1:0] i_lsu_rd;
  logic [WB_DATA_W-1:0] i_lsu_data;
  logic [WB_ADDR_W-1:0] o_rd_addr;
  logic [WB_DATA_W-1:0] o_rd_data;
  logic                 o_rd_wren;
  logic                 o_alu_stall;
  logic [31:0]          o_pending;
  logic                 o_err;

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  o_lsu_ready, o_rd_addr, o_rd_data, o_rd_wren,
    input  o_alu_stall, o_pending, o_err
  );

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_lsu_ready, o_rd_addr, o_rd_data, o_rd_wren,
    output o_alu_stall, o_pending, o_err
  );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for LSU writebacks.
//   i_clk, i_reset_n : clock, async active-low reset (empties the FIFO)
//   i_push, i_wdata  : enqueue (caller guarantees not full)
//   i_pop            : dequeue head (caller guarantees not empty)
//   o_head           : current head entry
//   o_count          : number of valid entries
//   o_ent_vld/o_ent_rd : per-slot valid and destination, for pending decode
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_push,
  input  wb_req_t                              i_wdata,
  input  logic                                 i_pop,
  output wb_req_t                              o_head,
  output logic [$clog2(DEPTH+1)-1:0]           o_count,
  output logic [DEPTH-1:0]                     o_ent_vld,
  output logic [DEPTH-1:0][WB_ADDR_W-1:0]      o_ent_rd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_req_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0]    vld_q, vld_d;

  // Per-slot valid bits; a slot never sees push and pop together since a
  // push needs a free slot and a pop needs an occupied one.
  always_comb begin
    vld_d = vld_q;
    if (i_pop)  vld_d[rd_ptr_q] = 1'b0;
    if (i_push) vld_d[wr_ptr_q] = 1'b1;
    cnt_d = cnt_q;
    case ({i_push, i_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (i_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_ent_rd[i] = mem_q[i].rd;
  end

  assign o_head    = mem_q[rd_ptr_q];
  assign o_count   = cnt_q;
  assign o_ent_vld = vld_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single integer register file write port.
// Merges the fixed-latency ALU (priority, no back-pressure) with a FIFO of
// LSU completions. A starvation counter forces a one-cycle ALU stall so the
// FIFO head drains; a pending-write mask is exported for the hazard unit.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus (slave)      : ALU/LSU inputs, register file port, stall/pending/err
// Parameters: DEPTH (LSU FIFO entries, power of two >= 2),
//             MAX_WAIT (lost arbitrations before a forced drain, >= 1).
// Build option: define WB_PENDING_EN to generate o_pending; otherwise it
// is tied to zero.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WAIT_W = $clog2(MAX_WAIT+1);

  wb_req_t                         fifo_head, lsu_req, gnt_req;
  logic [CNT_W-1:0]                fifo_cnt;
  logic [DEPTH-1:0]                ent_vld;
  logic [DEPTH-1:0][WB_ADDR_W-1:0] ent_rd;
  logic                            fifo_nempty, lsu_ready, lsu_push;
  logic                            gnt_alu, gnt_fifo, gnt_any;

  wb_req_t          out_q;
  logic             wren_q, wren_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             stall_q, stall_d;
  logic             err_q, err_d;
  logic [31:0]      pend;

  assign lsu_req   = '{rd: bus.i_lsu_rd, data: bus.i_lsu_data};
  assign lsu_ready = (fifo_cnt < CNT_W'(DEPTH));
  assign lsu_push  = bus.i_lsu_valid && lsu_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (lsu_push),
    .i_wdata   (lsu_req),
    .i_pop     (gnt_fifo),
    .o_head    (fifo_head),
    .o_count   (fifo_cnt),
    .o_ent_vld (ent_vld),
    .o_ent_rd  (ent_rd)
  );

  // Count is registered, so an entry pushed this cycle is not visible to
  // the grant until next cycle (no bypass).
  assign fifo_nempty = (fifo_cnt != '0);

  always_comb begin
    gnt_alu  = 1'b0;
    gnt_fifo = 1'b0;
    if (stall_q)               gnt_fifo = fifo_nempty;
    else if (bus.i_alu_valid)  gnt_alu  = 1'b1;
    else                       gnt_fifo = fifo_nempty;
    gnt_any = gnt_alu | gnt_fifo;
    gnt_req = gnt_alu ? wb_req_t'{rd: bus.i_alu_rd, data: bus.i_alu_data} : fifo_head;
    wren_d  = gnt_any && (gnt_req.rd != REG_X0);
    // Counter can only reach MAX_WAIT while the head is still queued, so
    // the forced-drain cycle always has a head to grant.
    wait_d  = (fifo_nempty && !gnt_fifo) ? wait_q + WAIT_W'(1) : '0;
    stall_d = (wait_d == WAIT_W'(MAX_WAIT));
    err_d   = err_q | (stall_q & bus.i_alu_valid);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q   <= '0;
      wren_q  <= 1'b0;
      wait_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (gnt_any) out_q <= gnt_req;
      wren_q  <= wren_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

`ifdef WB_PENDING_EN
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) if (ent_vld[i]) pend[ent_rd[i]] = 1'b1;
    if (wren_q) pend[out_q.rd] = 1'b1;
    pend[0] = 1'b0;
  end
`else
  logic unused_pend;
  assign unused_pend = ^{ent_vld, ent_rd};
  assign pend        = 32'h0;
`endif

  assign bus.o_lsu_ready = lsu_ready;
  assign bus.o_rd_addr   = out_q.rd;
  assign bus.o_rd_data   = out_q.data;
  assign bus.o_rd_wren   = wren_q;
  assign bus.o_alu_stall = stall_q;
  assign bus.o_pending   = pend;
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2, MAX_WAIT=4). Expected
// writes are queued when stimulus is driven and retired by a monitor that
// watches the register file port.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus_if();

  regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_if.slave)
  );

  int      checks = 0;
  int      errors = 0;
  int      wr_cnt = 0;
  int      wr_snap;
  wb_req_t alu_exp[$];
  wb_req_t lsu_exp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend(input int r);
`ifdef WB_PENDING_EN
    return 32'd1 << r;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.i_alu_valid = 1'b0;
    bus_if.i_lsu_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit exp_wr);
    wb_req_t e;
    bus_if.i_alu_valid = 1'b1;
    bus_if.i_alu_rd    = rd;
    bus_if.i_alu_data  = d;
    e.rd = rd; e.data = d;
    if (exp_wr && rd != 5'd0) alu_exp.push_back(e);
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d, input bit exp_wr);
    wb_req_t e;
    bus_if.i_lsu_valid = 1'b1;
    bus_if.i_lsu_rd    = rd;
    bus_if.i_lsu_data  = d;
    e.rd = rd; e.data = d;
    if (exp_wr && rd != 5'd0) lsu_exp.push_back(e);
  endtask

  // Scoreboard: each source is in order on its own, so a write must match
  // the head of one of the two expected queues.
  always @(negedge clk) begin
    wb_req_t got;
    logic    hit;
    if (rst_n && bus_if.o_rd_wren) begin
      got.rd   = bus_if.o_rd_addr;
      got.data = bus_if.o_rd_data;
      wr_cnt++;
      hit = 1'b0;
      if (alu_exp.size() != 0 && alu_exp[0] === got) begin
        hit = 1'b1; void'(alu_exp.pop_front());
      end else if (lsu_exp.size() != 0 && lsu_exp[0] === got) begin
        hit = 1'b1; void'(lsu_exp.pop_front());
      end
      checks++;
      assert (hit === 1'b1) else begin
        errors++;
        $error("FAIL wb_scoreboard observed rd=%0d data=%h expected=queued write", got.rd, got.data);
      end
    end
  end

  initial begin
    bus_if.i_alu_valid = 1'b0;
    bus_if.i_alu_rd    = '0;
    bus_if.i_alu_data  = '0;
    bus_if.i_lsu_valid = 1'b0;
    bus_if.i_lsu_rd    = '0;
    bus_if.i_lsu_data  = '0;
    repeat (3) step();

    // reset values
    chk("rst_addr",  bus_if.o_rd_addr, 0);
    chk("rst_data",  bus_if.o_rd_data, 0);
    chk("rst_wren",  bus_if.o_rd_wren, 0);
    chk("rst_stall", bus_if.o_alu_stall, 0);
    chk("rst_err",   bus_if.o_err, 0);
    chk("rst_pend",  bus_if.o_pending, 0);
    chk("rst_ready", bus_if.o_lsu_ready, 1);
    rst_n = 1'b1;
    step();

    // ALU single write, one-cycle latency
    alu(5'd5, 32'hDEADBEEF, 1);
    step(); idle();
    chk("alu_wren", bus_if.o_rd_wren, 1);
    chk("alu_addr", bus_if.o_rd_addr, 5);
    chk("alu_data", bus_if.o_rd_data, 32'hDEADBEEF);
    chk("alu_pend", bus_if.o_pending, pend(5));
    step();
    chk("alu_wren_off", bus_if.o_rd_wren, 0);
    chk("alu_pend_off", bus_if.o_pending, 0);

    // LSU single write, two-cycle latency
    chk("lsu_ready", bus_if.o_lsu_ready, 1);
    lsu(5'd7, 32'h12345678, 1);
    step(); idle();
    chk("lsu_pend_q",   bus_if.o_pending, pend(7));
    chk("lsu_nobypass", bus_if.o_rd_wren, 0);
    step();
    chk("lsu_wren", bus_if.o_rd_wren, 1);
    chk("lsu_addr", bus_if.o_rd_addr, 7);
    chk("lsu_data", bus_if.o_rd_data, 32'h12345678);
    chk("lsu_pend_out", bus_if.o_pending, pend(7));
    step();
    chk("lsu_pend_off", bus_if.o_pending, 0);

    // FIFO full under ALU pressure, then forced drain
    step();
    chk("full_rdy0", bus_if.o_lsu_ready, 1);
    alu(5'd1, 32'hA0000001, 1); lsu(5'd10, 32'h5000000A, 1);
    step();
    chk("full_rdy1", bus_if.o_lsu_ready, 1);
    alu(5'd2, 32'hA0000002, 1); lsu(5'd11, 32'h5000000B, 1);
    step();
    chk("full_rdy_lo", bus_if.o_lsu_ready, 0);
    alu(5'd3, 32'hA0000003, 1); lsu(5'd12, 32'h5000000C, 0);
    step();
    chk("full_held", bus_if.o_lsu_ready, 0);
    chk("stall_early3", bus_if.o_alu_stall, 0);
    alu(5'd4, 32'hA0000004, 1);
    step();
    chk("stall_early4", bus_if.o_alu_stall, 0);
    alu(5'd5, 32'hA0000005, 1);
    step();
    chk("stall_on", bus_if.o_alu_stall, 1);
    chk("stall_rdy", bus_if.o_lsu_ready, 0);
    bus_if.i_alu_valid = 1'b0;
    step();
    chk("stall_1cyc", bus_if.o_alu_stall, 0);
    chk("drain_wren", bus_if.o_rd_wren, 1);
    chk("drain_addr", bus_if.o_rd_addr, 10);
    chk("drain_data", bus_if.o_rd_data, 32'h5000000A);
    chk("drain_rdy", bus_if.o_lsu_ready, 1);
    chk("drain_err", bus_if.o_err, 0);
    begin
      wb_req_t e;
      e.rd = 5'd12; e.data = 32'h5000000C;
      lsu_exp.push_back(e);
    end
    alu(5'd6, 32'hA0000006, 1);
    step(); bus_if.i_lsu_valid = 1'b0; alu(5'd7, 32'hA0000007, 1);
    step(); alu(5'd8, 32'hA0000008, 1);
    step(); idle();
    step();
    chk("drain2_addr", bus_if.o_rd_addr, 11);
    step();
    chk("drain3_addr", bus_if.o_rd_addr, 12);
    chk("drain3_data", bus_if.o_rd_data, 32'h5000000C);
    step();
    chk("empty_rdy", bus_if.o_lsu_ready, 1);
    chk("empty_stall", bus_if.o_alu_stall, 0);

    // stall violation: ALU ignored, sticky error
    alu(5'd14, 32'hA000000E, 1); lsu(5'd13, 32'h5000000D, 1);
    step(); bus_if.i_lsu_valid = 1'b0; alu(5'd15, 32'hA000000F, 1);
    step(); alu(5'd16, 32'hA0000010, 1);
    step(); alu(5'd17, 32'hA0000011, 1);
    step(); alu(5'd18, 32'hA0000012, 1);
    step();
    chk("viol_stall", bus_if.o_alu_stall, 1);
    chk("viol_err_pre", bus_if.o_err, 0);
    alu(5'd3, 32'h00000BAD, 0);
    step(); idle();
    chk("viol_err", bus_if.o_err, 1);
    chk("viol_addr", bus_if.o_rd_addr, 13);
    chk("viol_data", bus_if.o_rd_data, 32'h5000000D);
    repeat (3) step();
    chk("err_sticky", bus_if.o_err, 1);

    // x0 handling
    alu(5'd0, 32'h11110000, 0);
    step(); idle();
    chk("alu_x0_wren", bus_if.o_rd_wren, 0);
    chk("alu_x0_data", bus_if.o_rd_data, 32'h11110000);
    chk("alu_x0_pend", bus_if.o_pending, 0);
    step();
    lsu(5'd0, 32'h22220000, 0);
    step(); idle();
    chk("lsu_x0_pend", bus_if.o_pending, 0);
    step();
    chk("lsu_x0_wren", bus_if.o_rd_wren, 0);
    chk("lsu_x0_pop",  bus_if.o_rd_data, 32'h22220000);
    step();
    chk("lsu_x0_rdy", bus_if.o_lsu_ready, 1);

    // reset with two entries queued
    alu(5'd22, 32'hA0000016, 1); lsu(5'd20, 32'h50000014, 0);
    step(); alu(5'd23, 32'hA0000017, 0); lsu(5'd21, 32'h50000015, 0);
    step();
    chk("mrst_full", bus_if.o_lsu_ready, 0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mrst_wren",  bus_if.o_rd_wren, 0);
    chk("mrst_addr",  bus_if.o_rd_addr, 0);
    chk("mrst_data",  bus_if.o_rd_data, 0);
    chk("mrst_rdy",   bus_if.o_lsu_ready, 1);
    chk("mrst_pend",  bus_if.o_pending, 0);
    chk("mrst_err",   bus_if.o_err, 0);
    repeat (2) step();
    wr_snap = wr_cnt;
    rst_n = 1'b1;
    repeat (6) step();
    chk("mrst_nowrite", wr_cnt, wr_snap);
    chk("mrst_stall",   bus_if.o_alu_stall, 0);
    chk("alu_q_empty",  alu_exp.size(), 0);
    chk("lsu_q_empty",  lsu_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
